btn_event_conditioner: RTL and testbench

- Upstream stage of the pet-brain FSM. Takes the raw asynchronous push-buttons (heal, feed, reset, test) and turns each into clean events.
- Per button it synchronises the input, debounces press and release, and classifies each press as short or long.
- Outputs are a debounced level, a one-cycle short-press pulse and a one-cycle long-press pulse. The FSM consumes these instead of raw pins; the long press drives the 5 s reset and test-mode entry.

---
 rtl/btn_pkg.sv | 33 +++
 rtl/btn_channel.sv | 174 +++++++++++++++++
 rtl/btn_event_conditioner.sv | 58 +++++
 tb/tb_btn_event_conditioner.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared definitions for the button event conditioner.
//                Provides the 3-bit channel state encodings and the button
//                channel index constants that the brain FSM also uses.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Channel state encodings (3-bit)
    localparam logic [2:0] LOCKOUT   = 3'd0;
    localparam logic [2:0] IDLE      = 3'd1;
    localparam logic [2:0] DEB_PRESS = 3'd2;
    localparam logic [2:0] HELD      = 3'd3;
    localparam logic [2:0] DEB_REL   = 3'd4;

    typedef enum logic [2:0] {
        ST_LOCKOUT   = LOCKOUT,
        ST_IDLE      = IDLE,
        ST_DEB_PRESS = DEB_PRESS,
        ST_HELD      = HELD,
        ST_DEB_REL   = DEB_REL
    } btn_state_e;

    // Channel index of each physical button
    localparam int BTN_HEAL = 0;
    localparam int BTN_FEED = 1;
    localparam int BTN_RST  = 2;
    localparam int BTN_TST  = 3;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
//  Module      : btn_channel
//  Description : One button channel: 2-flop synchroniser, press/release
//                debounce, short/long press classification. The input is
//                already polarity-normalised (1 = pressed).
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 250_000_000
) (
    input  logic clk,
    input  logic rst,          // asynchronous, active-low
    input  logic pressed_raw,  // asynchronous, 1 = pressed
    output logic level,
    output logic short_evt,
    output logic long_evt,
    output logic active_next   // channel will be outside IDLE next cycle
);

    localparam int CNT_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LOCK  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYCLES - 1);

    logic              sync_q1;
    logic              sync_q2;
    logic              s;

    btn_state_e        state;
    btn_state_e        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;
    logic [HOLD_W-1:0] hold_step;
    logic              long_done;
    logic              long_done_nxt;
    logic              level_nxt;
    logic              short_nxt;
    logic              long_nxt;
    logic              holding;
    logic              long_fire;

    // Two-flop synchroniser; resets to "pressed" so a held button stays locked out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= pressed_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign s         = sync_q2;
    assign holding   = (state == ST_HELD) || (state == ST_DEB_REL);
    assign hold_step = (hold < HOLD_MAX) ? hold + HOLD_W'(1) : hold;
    assign long_fire = holding && (hold == HOLD_LONG) && !long_done;

    // State, counters and registered event outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_LOCKOUT;
            cnt       <= '0;
            hold      <= '0;
            long_done <= 1'b0;
            level     <= 1'b0;
            short_evt <= 1'b0;
            long_evt  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hold      <= hold_nxt;
            long_done <= long_done_nxt;
            level     <= level_nxt;
            short_evt <= short_nxt;
            long_evt  <= long_nxt;
        end
    end

    // Next-state, counter and event decode
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hold_nxt      = hold;
        long_done_nxt = long_done;
        level_nxt     = level;
        short_nxt     = 1'b0;
        long_nxt      = 1'b0;

        // Hold time keeps running through release bounce, so the long event
        // can fire from either HELD or DEB_REL.
        if (holding) begin
            hold_nxt = hold_step;
            if (long_fire) begin
                long_nxt      = 1'b1;
                long_done_nxt = 1'b1;
            end
        end

        case (state)
            ST_LOCKOUT: begin
                level_nxt = 1'b0;
                if (s) begin
                    cnt_nxt = '0;
                end else if (cnt >= CNT_LOCK) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_IDLE: begin
                level_nxt = 1'b0;
                cnt_nxt   = '0;
                if (s) begin
                    state_nxt = ST_DEB_PRESS;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_DEB_PRESS: begin
                if (!s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_nxt     = ST_HELD;
                    cnt_nxt       = '0;
                    level_nxt     = 1'b1;
                    hold_nxt      = '0;
                    long_done_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_nxt = ST_DEB_REL;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_DEB_REL: begin
                if (s) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    // A long event in this same cycle still counts as long
                    short_nxt = !long_done && !long_fire;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_LOCKOUT;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

    assign active_next = (state_nxt != ST_IDLE);

endmodule : btn_channel
`default_nettype wire

// File: rtl/btn_event_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_conditioner
//  Description : Turns raw asynchronous push-buttons into debounced levels
//                and one-cycle short/long press events, one channel per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_event_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 250_000_000,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] short_o,
    output logic [N_BTN-1:0] long_o,
    output logic             busy_o
);

    logic [N_BTN-1:0] pressed_raw;
    logic [N_BTN-1:0] active_next;

    // Normalise polarity so every channel sees 1 = pressed
    assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_chan
            btn_channel #(
                .DEB_CYCLES  (DEB_CYCLES),
                .LONG_CYCLES (LONG_CYCLES)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .pressed_raw (pressed_raw[i]),
                .level       (btn_level_o[i]),
                .short_evt   (short_o[i]),
                .long_evt    (long_o[i]),
                .active_next (active_next[i])
            );
        end
    endgenerate

    // Registered busy flag, aligned with the channel state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_o <= 1'b0;
        end else begin
            busy_o <= |active_next;
        end
    end

endmodule : btn_event_conditioner
`default_nettype wire

// File: tb/tb_btn_event_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_event_conditioner
//  Description : Scoreboard bench for btn_event_conditioner with
//                DEB_CYCLES=4, LONG_CYCLES=20, active-high buttons.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_event_conditioner;

    localparam int N_BTN       = 4;
    localparam int DEB_CYCLES  = 4;
    localparam int LONG_CYCLES = 20;

    localparam int K_RISE  = 0;
    localparam int K_FALL  = 1;
    localparam int K_SHORT = 2;
    localparam int K_LONG  = 3;

    // Input sampled at the edge after it is driven; 2 sync + DEB_CYCLES+1
    // clocks of debounce -> event visible 7 cycles after the drive cycle.
    localparam int LAT = 7;

    typedef struct {
        int cyc;
        int idx;
        int kind;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N_BTN-1:0] btn = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] short_p;
    logic [N_BTN-1:0] long_p;
    logic             busy;

    int  cyc        = 0;
    int  compared   = 0;
    int  mismatched = 0;
    ev_t exp_q[$];
    logic [N_BTN-1:0] prev_level = '0;

    btn_event_conditioner #(
        .N_BTN       (N_BTN),
        .DEB_CYCLES  (DEB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES),
        .ACTIVE_LOW  (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_i       (btn),
        .btn_level_o (btn_level),
        .short_o     (short_p),
        .long_o      (long_p),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_RISE:  return "rise";
            K_FALL:  return "fall";
            K_SHORT: return "short";
            default: return "long";
        endcase
    endfunction

    function automatic void expect_ev(input int c, input int idx, input int kind);
        ev_t e;
        e.cyc  = c;
        e.idx  = idx;
        e.kind = kind;
        exp_q.push_back(e);
    endfunction

    task automatic observe(input int idx, input int kind);
        ev_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL event: actual %s bit%0d at cycle %0d, required none",
                     kname(kind), idx, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.idx != idx || e.kind != kind) begin
                mismatched++;
                $display("FAIL event: actual %s bit%0d at cycle %0d, required %s bit%0d at cycle %0d",
                         kname(kind), idx, cyc, kname(e.kind), e.idx, e.cyc);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: turn every observable output event into a scoreboard pop
    always @(negedge clk) begin
        if (rst) begin
            for (int b = 0; b < N_BTN; b++) begin
                if (btn_level[b] && !prev_level[b]) observe(b, K_RISE);
                if (!btn_level[b] && prev_level[b]) observe(b, K_FALL);
                if (short_p[b]) observe(b, K_SHORT);
                if (long_p[b])  observe(b, K_LONG);
            end
        end
        prev_level <= btn_level;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int d;
        tick(3);
        check("reset_level", 32'(btn_level), 32'h0);
        check("reset_short", 32'(short_p), 32'h0);
        check("reset_long",  32'(long_p), 32'h0);
        check("reset_busy",  32'(busy), 32'h0);
        rst = 1'b1;
        tick(12);
        check("lockout_exit_busy", 32'(busy), 32'h0);

        // Glitch on bit 0: three clocks only, rejected
        d = cyc;
        btn[0] = 1'b1;
        tick(3);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        btn[0] = 1'b0;
        tick(10);
        check("glitch_busy_idle", 32'(busy), 32'h0);
        check("glitch_level", 32'(btn_level), 32'h0);

        // Short press on bit 0
        d = cyc;
        expect_ev(d + LAT, 0, K_RISE);
        expect_ev(d + 10 + LAT, 0, K_FALL);
        expect_ev(d + 10 + LAT, 0, K_SHORT);
        btn[0] = 1'b1;
        tick(10);
        btn[0] = 1'b0;
        tick(15);

        // Long press on bit 2, released after 40 clocks, no short
        d = cyc;
        expect_ev(d + LAT, 2, K_RISE);
        expect_ev(d + LAT + LONG_CYCLES, 2, K_LONG);
        expect_ev(d + 40 + LAT, 2, K_FALL);
        btn[2] = 1'b1;
        tick(40);
        btn[2] = 1'b0;
        tick(15);

        // Bounce on bit 1 while held: level stays up, hold keeps counting
        d = cyc;
        expect_ev(d + LAT, 1, K_RISE);
        expect_ev(d + LAT + LONG_CYCLES, 1, K_LONG);
        expect_ev(d + 35 + LAT, 1, K_FALL);
        btn[1] = 1'b1;
        tick(10);
        for (int i = 0; i < 6; i++) begin
            btn[1] = (i % 2 == 1);
            tick(1);
        end
        tick(3);
        check("bounce_level", 32'(btn_level[1]), 32'h1);
        tick(16);
        btn[1] = 1'b0;
        tick(15);

        // Bit 3 held through reset: locked out until released
        btn[3] = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("midreset_level", 32'(btn_level), 32'h0);
        check("midreset_busy",  32'(busy), 32'h0);
        tick(2);
        rst = 1'b1;
        tick(15);
        check("lockout_level3", 32'(btn_level[3]), 32'h0);
        check("lockout_busy",   32'(busy), 32'h1);
        btn[3] = 1'b0;
        tick(10);
        check("lockout_release_busy", 32'(busy), 32'h0);
        d = cyc;
        expect_ev(d + LAT, 3, K_RISE);
        expect_ev(d + 10 + LAT, 3, K_FALL);
        expect_ev(d + 10 + LAT, 3, K_SHORT);
        btn[3] = 1'b1;
        tick(10);
        btn[3] = 1'b0;
        tick(12);

        // Simultaneous short presses on bits 0 and 1
        d = cyc;
        expect_ev(d + LAT, 0, K_RISE);
        expect_ev(d + LAT, 1, K_RISE);
        expect_ev(d + 8 + LAT, 0, K_FALL);
        expect_ev(d + 8 + LAT, 0, K_SHORT);
        expect_ev(d + 8 + LAT, 1, K_FALL);
        expect_ev(d + 8 + LAT, 1, K_SHORT);
        btn[1:0] = 2'b11;
        tick(1);
        check("dual_busy_pre", 32'(busy), 32'h0);
        tick(3);
        check("dual_busy_press", 32'(busy), 32'h1);
        tick(4);
        btn[1:0] = 2'b00;
        tick(6);
        check("dual_busy_release", 32'(busy), 32'h1);
        tick(1);
        check("dual_busy_idle", 32'(busy), 32'h0);
        tick(6);

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL event: actual none, required %s bit%0d at cycle %0d",
                     kname(e.kind), e.idx, e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_btn_event_conditioner
`default_nettype wire
